// File: rtl/pattern_sequencer_if.sv
// Game-to-lane control bundle for pattern_sequencer: lane request/hit strobes in, patterns and score out.
// Request semantics: start is a level sampled in IDLE; trocar and ponto are level signals whose 0->1 transitions are the events (held high = one event); there is no valid/ready back-pressure.
interface pattern_sequencer_if;
  logic        start;
  logic        trocar;
  logic        ponto;
  logic [3:0]  command_out;
  logic [3:0]  preview;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [3:0]  level;
  logic [27:0] step_period;
  logic        playing;

  modport master (
    output start, trocar, ponto,
    input  command_out, preview, score, combo, level, step_period, playing
  );

  modport slave (
    input  start, trocar, ponto,
    output command_out, preview, score, combo, level, step_period, playing
  );
endinterface

// File: rtl/pattern_sequencer.sv
// LFSR-fed pattern queue plus score/combo/level tracking for the falling-note lane.
// Optional PATTERN_NO_REPEAT_EN: never queue the same pattern twice in a row.
module pattern_sequencer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          BASE_PERIOD = 200000,
  parameter int          PERIOD_STEP = 10000,
  parameter int          MIN_PERIOD  = 50000,
  parameter int          LEVEL_HITS  = 16
) (
  input  logic              CLOCK_25,
  input  logic              reset,
  pattern_sequencer_if.slave bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  localparam int          IDX_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          HIT_W  = $clog2(LEVEL_HITS + 1);
  localparam logic [27:0] BASE_P = 28'(BASE_PERIOD);
  localparam logic [27:0] STEP_P = 28'(PERIOD_STEP);
  localparam logic [27:0] MIN_P  = 28'(MIN_PERIOD);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] fill_idx;
  logic [3:0]       queue [QUEUE_DEPTH];
  logic [15:0]      lfsr;
  logic             trocar_d, ponto_d;
  logic             trocar_rise, ponto_rise;
  logic             hit_seen;
  logic [HIT_W-1:0] hit_cnt;
  logic [3:0]       cand_raw, candidate;
  logic             fill_en, play_en, fill_last;

  assign trocar_rise = bus.trocar & ~trocar_d;
  assign ponto_rise  = bus.ponto & ~ponto_d;
  assign fill_last   = (state == S_FILL) && (fill_idx == IDX_W'(QUEUE_DEPTH - 1));

  // State register
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_FILL;
      S_FILL:  if (fill_last) state_nxt = S_PLAY;
      S_PLAY:  state_nxt = S_PLAY;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    fill_en     = 1'b0;
    play_en     = 1'b0;
    bus.playing = 1'b0;
    case (state)
      S_FILL:  fill_en = 1'b1;
      S_PLAY:  begin play_en = 1'b1; bus.playing = 1'b1; end
      default: ;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      lfsr     <= LFSR_SEED;
      trocar_d <= 1'b0;
      ponto_d  <= 1'b0;
    end else begin
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      trocar_d <= bus.trocar;
      ponto_d  <= bus.ponto;
    end
  end

  // Zero nibbles fall through to the next nibble, then to 1, so a lane never gets an empty pattern.
  always_comb begin
    cand_raw = lfsr[3:0];
    if (cand_raw == 4'd0) cand_raw = lfsr[7:4];
    if (cand_raw == 4'd0) cand_raw = 4'b0001;
  end

`ifdef PATTERN_NO_REPEAT_EN
  logic [3:0] last_written;
  logic [3:0] cand_bump;

  assign cand_bump = cand_raw + 4'd1;
  assign candidate = (cand_raw != last_written) ? cand_raw :
                     ((cand_bump == 4'd0) ? 4'b0001 : cand_bump);

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset)                             last_written <= 4'd0;
    else if (fill_en || (play_en && trocar_rise)) last_written <= candidate;
  end
`else
  assign candidate = cand_raw;
`endif

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      fill_idx <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) queue[i] <= 4'd0;
    end else begin
      fill_idx <= fill_en ? fill_idx + IDX_W'(1) : '0;
      if (fill_en) begin
        queue[fill_idx] <= candidate;
      end else if (play_en && trocar_rise) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) queue[i] <= queue[i+1];
        queue[QUEUE_DEPTH-1] <= candidate;
      end
    end
  end

  assign bus.command_out = queue[0];
  assign bus.preview     = queue[1];

  // A hit arriving with the request is credited to the outgoing pattern, so it is not a miss.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      bus.score       <= 16'd0;
      bus.combo       <= 8'd0;
      bus.level       <= 4'd0;
      bus.step_period <= BASE_P;
      hit_cnt         <= '0;
      hit_seen        <= 1'b0;
    end else if (play_en) begin
      if (ponto_rise) begin
        if (bus.score != 16'hFFFF) bus.score <= bus.score + 16'd1;
        if (bus.combo != 8'hFF)    bus.combo <= bus.combo + 8'd1;
        if (hit_cnt == HIT_W'(LEVEL_HITS - 1)) begin
          hit_cnt <= '0;
          if (bus.level != 4'd15) begin
            bus.level       <= bus.level + 4'd1;
            bus.step_period <= (bus.step_period >= MIN_P + STEP_P) ?
                               bus.step_period - STEP_P : MIN_P;
          end
        end else begin
          hit_cnt <= hit_cnt + HIT_W'(1);
        end
      end
      if (trocar_rise) begin
        if (!hit_seen && !ponto_rise) bus.combo <= 8'd0;
        hit_seen <= 1'b0;
      end else if (ponto_rise) begin
        hit_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: per-cycle reference model with scoreboard, scoring table, corner sequences.
module tb_pattern_sequencer;

  localparam int DEPTH = 4;

  logic       CLOCK_25;
  logic       reset;
  logic [1:0] state_dbg;

  pattern_sequencer_if bus_if ();

  pattern_sequencer dut (
    .CLOCK_25  (CLOCK_25),
    .reset     (reset),
    .bus       (bus_if),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    CLOCK_25 = 1'b0;
    forever #5 CLOCK_25 = ~CLOCK_25;
  end

  // Reference model state
  int         m_state, m_fill, m_score, m_combo, m_level, m_period, m_hits;
  logic [3:0] m_q [DEPTH];
  logic [3:0] m_last;
  logic [15:0] m_lfsr;
  logic       m_tr_d, m_po_d, m_hit;

  logic [66:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic tr;
    logic po;
    int   score;
    int   combo;
    int   level;
    int   period;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] cand(input logic [15:0] l, input logic [3:0] last);
    logic [3:0] c;
    c = l[3:0];
    if (c == 4'd0) c = l[7:4];
    if (c == 4'd0) c = 4'd1;
`ifdef PATTERN_NO_REPEAT_EN
    if (c == last) begin
      c = c + 4'd1;
      if (c == 4'd0) c = 4'd1;
    end
`endif
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_score = 0; m_combo = 0; m_level = 0;
    m_period = 200000; m_hits = 0; m_last = 4'd0; m_lfsr = 16'hACE1;
    m_tr_d = 1'b0; m_po_d = 1'b0; m_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_q[i] = 4'd0;
  endtask

  task automatic model_step(input logic st, input logic tr, input logic po);
    logic tr_r, po_r;
    logic [3:0] c;
    tr_r = tr && !m_tr_d;
    po_r = po && !m_po_d;
    m_tr_d = tr;
    m_po_d = po;
    c = cand(m_lfsr, m_last);
    if (m_state == 0) begin
      if (st) begin m_state = 1; m_fill = 0; end
    end else if (m_state == 1) begin
      m_q[m_fill] = c;
      m_last = c;
      if (m_fill == DEPTH - 1) m_state = 2;
      else m_fill++;
    end else begin
      if (po_r) begin
        if (m_score < 65535) m_score++;
        if (m_combo < 255) m_combo++;
        m_hits++;
        if (m_hits == 16) begin
          m_hits = 0;
          if (m_level < 15) begin
            m_level++;
            m_period = (m_period - 10000 < 50000) ? 50000 : m_period - 10000;
          end
        end
      end
      if (tr_r) begin
        for (int i = 0; i < DEPTH - 1; i++) m_q[i] = m_q[i+1];
        m_q[DEPTH-1] = c;
        m_last = c;
        if (!m_hit && !po_r) m_combo = 0;
        m_hit = 1'b0;
      end else if (po_r) begin
        m_hit = 1'b1;
      end
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  endtask

  function automatic logic [66:0] model_vec();
    return {2'(m_state), m_q[0], m_q[1], 16'(m_score), 8'(m_combo), 4'(m_level),
            28'(m_period), (m_state == 2)};
  endfunction

  function automatic logic [66:0] dut_vec();
    return {state_dbg, bus_if.command_out, bus_if.preview, bus_if.score, bus_if.combo,
            bus_if.level, bus_if.step_period, bus_if.playing};
  endfunction

  // Driver: one clock cycle of inputs, starting just after a falling edge.
  task automatic step(input logic st, input logic tr, input logic po);
    logic [66:0] e;
    bus_if.start  = st;
    bus_if.trocar = tr;
    bus_if.ponto  = po;
    model_step(st, tr, po);
    exp_q.push_back(model_vec());
    @(posedge CLOCK_25);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 67'd1, 67'd0);
    end else begin
      e = exp_q.pop_front();
      check("cycle", dut_vec(), e);
    end
    @(negedge CLOCK_25);
  endtask

  task automatic apply_reset();
    bus_if.start = 1'b0; bus_if.trocar = 1'b0; bus_if.ponto = 1'b0;
    @(posedge CLOCK_25);
    #3;
    reset = 1'b1;
    #1;
    check("rst_cmd",     67'(bus_if.command_out), 67'd0);
    check("rst_preview", 67'(bus_if.preview),     67'd0);
    check("rst_score",   67'(bus_if.score),       67'd0);
    check("rst_combo",   67'(bus_if.combo),       67'd0);
    check("rst_level",   67'(bus_if.level),       67'd0);
    check("rst_period",  67'(bus_if.step_period), 67'd200000);
    check("rst_playing", 67'(bus_if.playing),     67'd0);
    check("rst_state",   67'(state_dbg),          67'd0);
    model_reset();
    @(negedge CLOCK_25);
    reset = 1'b0;
  endtask

  task automatic start_seq();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= DEPTH; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("start_playing", 67'(bus_if.playing), (k < DEPTH) ? 67'd0 : 67'd1);
    end
    check("start_cmd_nz",     67'(bus_if.command_out != 4'd0), 67'd1);
    check("start_preview_nz", 67'(bus_if.preview != 4'd0),     67'd1);
  endtask

  initial begin
    logic [3:0] prev_dut, prev_mod, saved;
    int dut_rep, mod_rep;

    tbl[0] = '{1'b0, 1'b1, 1, 1, 0, 200000};
    tbl[1] = '{1'b1, 1'b0, 1, 1, 0, 200000};
    tbl[2] = '{1'b1, 1'b0, 1, 0, 0, 200000};
    tbl[3] = '{1'b0, 1'b1, 2, 1, 0, 200000};
    tbl[4] = '{1'b1, 1'b1, 3, 2, 0, 200000};
    tbl[5] = '{1'b1, 1'b0, 3, 0, 0, 200000};
    tbl[6] = '{1'b0, 1'b1, 4, 1, 0, 200000};
    tbl[7] = '{1'b0, 1'b1, 5, 2, 0, 200000};
    tbl[8] = '{1'b1, 1'b0, 5, 2, 0, 200000};

    reset = 1'b1;
    bus_if.start = 1'b0; bus_if.trocar = 1'b0; bus_if.ponto = 1'b0;
    model_reset();
    @(negedge CLOCK_25);
    @(negedge CLOCK_25);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);   // edges outside PLAY do nothing
    step(1'b0, 1'b0, 1'b0);

    start_seq();

    for (int i = 0; i < 9; i++) begin
      step(1'b0, tbl[i].tr, tbl[i].po);
      step(1'b0, 1'b0, 1'b0);
      check("tbl_score",  67'(bus_if.score),       67'(tbl[i].score));
      check("tbl_combo",  67'(bus_if.combo),       67'(tbl[i].combo));
      check("tbl_level",  67'(bus_if.level),       67'(tbl[i].level));
      check("tbl_period", 67'(bus_if.step_period), 67'(tbl[i].period));
    end

    // Held request shifts once; start is ignored in PLAY.
    saved = bus_if.preview;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("held_shift", 67'(bus_if.command_out), 67'(saved));

    apply_reset();
    start_seq();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    check("hit16_score",  67'(bus_if.score),       67'd16);
    check("hit16_combo",  67'(bus_if.combo),       67'd16);
    check("hit16_level",  67'(bus_if.level),       67'd1);
    check("hit16_period", 67'(bus_if.step_period), 67'd190000);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("miss_combo", 67'(bus_if.combo), 67'd0);
    check("miss_score", 67'(bus_if.score), 67'd16);

    apply_reset();
    start_seq();
    dut_rep = 0; mod_rep = 0;
    prev_dut = bus_if.command_out;
    prev_mod = m_q[0];
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("req_cmd_nz", 67'(bus_if.command_out != 4'd0), 67'd1);
      if (bus_if.command_out == prev_dut) dut_rep++;
      if (m_q[0] == prev_mod) mod_rep++;
      prev_dut = bus_if.command_out;
      prev_mod = m_q[0];
      step(1'b0, 1'b0, 1'b0);
    end
`ifdef PATTERN_NO_REPEAT_EN
    check("no_repeat", 67'(dut_rep), 67'd0);
`else
    check("model_has_repeat", 67'(mod_rep > 0), 67'd1);
`endif

    apply_reset();
    start_seq();
    for (int i = 0; i < 240; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    check("lvl15_level",  67'(bus_if.level),       67'd15);
    check("lvl15_period", 67'(bus_if.step_period), 67'd50000);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end
    check("sat_combo",  67'(bus_if.combo),       67'd255);
    check("sat_score",  67'(bus_if.score),       67'd300);
    check("sat_level",  67'(bus_if.level),       67'd15);
    check("sat_period", 67'(bus_if.step_period), 67'd50000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
